// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit memory requester.
//   - funct3 size/sign codes (LS_B, LS_H, LS_W, LS_BU, LS_HU)
//   - lsu_state_t: requester FSM states
//   - is_aligned / is_illegal: request classification helpers
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // True when the access fits naturally inside its own size boundary.
  // Only meaningful for legal funct3 codes.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      LS_B, LS_BU: ok = 1'b1;
      LS_H, LS_HU: ok = ~addr_lo[0];
      LS_W:        ok = (addr_lo == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Reserved size codes, or a store asking for an unsigned (load-only) size.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic bad;
    case (funct3)
      LS_B, LS_H, LS_W: bad = 1'b0;
      LS_BU, LS_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero extension of a right-justified load result.
// Ports:
//   funct3   in  3   size/sign code (lsu_pkg encoding)
//   data_in  in  32  assembled load data, right-justified
//   data_out out 32  extended load data
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (funct3)
      LS_B:    data_out = {{24{data_in[7]}}, data_in[7:0]};
      LS_H:    data_out = {{16{data_in[15]}}, data_in[15:0]};
      LS_BU:   data_out = {24'b0, data_in[7:0]};
      LS_HU:   data_out = {16'b0, data_in[15:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/lsu_mem_requester.sv
// lsu_mem_requester: initiator side of the data-memory port.
// Accepts one load/store at a time over valid/ready, issues a single memory
// cycle for aligned accesses and a sequence of byte accesses for misaligned
// ones, then returns a one-cycle response.
// Configuration macro: LSU_MISALIGN_TRAP_EN - when defined, misaligned legal
// requests are answered with rsp_err instead of being split.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_funct3 : core request
//   rsp_valid/rsp_rdata/rsp_err                              : core response
//   mem_addr/mem_wdata/mem_mask/mem_wr_en/mem_rd_en/mem_rdata : memory port
module lsu_mem_requester
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_mask,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state;
  logic                  cap_we;
  logic                  cap_err;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [2:0]            cap_funct3;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] ext_data;

`ifndef LSU_MISALIGN_TRAP_EN
  logic [1:0] idx;
  logic [1:0] split_last;

  // Halfwords need two byte accesses, words four.
  assign split_last = (cap_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
`endif

  lsu_load_extend u_ext (
    .funct3  (cap_funct3),
    .data_in (result),
    .data_out(ext_data)
  );

  // Request capture and sequencing. The result register is cleared on capture
  // so split loads can fill it byte by byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cap_we     <= 1'b0;
      cap_err    <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_funct3 <= 3'b000;
      result     <= '0;
`ifndef LSU_MISALIGN_TRAP_EN
      idx        <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we     <= req_we;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_funct3 <= req_funct3;
            result     <= '0;
`ifndef LSU_MISALIGN_TRAP_EN
            idx        <= 2'd0;
`endif
            if (is_illegal(req_we, req_funct3)) begin
              cap_err <= 1'b1;
              state   <= RESP;
            end else if (is_aligned(req_funct3, req_addr[1:0])) begin
              cap_err <= 1'b0;
              state   <= ACCESS;
            end else begin
`ifdef LSU_MISALIGN_TRAP_EN
              cap_err <= 1'b1;
              state   <= RESP;
`else
              cap_err <= 1'b0;
              state   <= SPLIT;
`endif
            end
          end
        end
        ACCESS: begin
          if (!cap_we) begin
            result <= mem_rdata;
          end
          state <= RESP;
        end
`ifndef LSU_MISALIGN_TRAP_EN
        SPLIT: begin
          if (!cap_we) begin
            result[{idx, 3'b000} +: 8] <= mem_rdata[7:0];
          end
          if (idx == split_last) begin
            state <= RESP;
          end else begin
            idx <= idx + 2'd1;
          end
        end
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Core-side handshake and response. Data is forced to zero for stores and
  // errored requests so the core never sees stale load data.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && cap_err;
    rsp_rdata = '0;
    if ((state == RESP) && !cap_err && !cap_we) begin
      rsp_rdata = ext_data;
    end
  end

  // Memory-side drive. Everything idles at zero outside the access states,
  // and exactly one of the enables is high inside them.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = 3'b000;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    case (state)
      ACCESS: begin
        mem_addr  = cap_addr;
        mem_mask  = cap_funct3;
        mem_wdata = cap_wdata;
        mem_wr_en = cap_we;
        mem_rd_en = ~cap_we;
      end
`ifndef LSU_MISALIGN_TRAP_EN
      SPLIT: begin
        mem_addr  = cap_addr + ADDR_WIDTH'(idx);
        mem_mask  = cap_we ? LS_B : LS_BU;
        mem_wr_en = cap_we;
        mem_rd_en = ~cap_we;
        if (cap_we) begin
          mem_wdata = {{(DATA_WIDTH-8){1'b0}}, cap_wdata[{idx, 3'b000} +: 8]};
        end
      end
`endif
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

endmodule
